mb32_req_arbiter: RTL and testbench

//  Shares one pipelined radix-8 Booth multiplier (mb32_top plus its pre_process_be encoder) between NREQ requesters.

---
 rtl/mb32_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mb32_req_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb32_req_arbiter.sv
// ----------------------------------------------------------------------------
// mb32_req_arbiter
// Shares one pipelined radix-8 Booth multiplier between NREQ requesters.
// A round-robin arbiter issues at most one operand pair per cycle into the
// multiplier operand registers (with tmy = 3*my precomputed). A tag pipeline
// follows each op through the fixed-latency multiplier, and finished products
// land in a result FIFO that the consumer may backpressure. Issue is gated by
// a credit check so the non-stallable pipeline can never overflow the FIFO.
//
// Ports
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   req_valid/ready per-requester handshake; req_ready is one-hot or zero
//   req_mx/req_my   packed operands, requester k at [k*WIDTH +: WIDTH]
//   mul_mx/my/tmy   registered operands toward the multiplier
//   mul_issue       mul_* registers hold a newly issued op this cycle
//   mul_product     multiplier result, MUL_LAT cycles after issue
//   rsp_*           result FIFO head (valid/ready handshake, id, product)
//   inflight        ops currently travelling through the multiplier
// ----------------------------------------------------------------------------
module mb32_req_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IDW        = 2,
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_mx,
  input  logic [NREQ*WIDTH-1:0] req_my,
  output logic [WIDTH-1:0]      mul_mx,
  output logic [WIDTH-1:0]      mul_my,
  output logic [WIDTH+1:0]      mul_tmy,
  output logic                  mul_issue,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic [IDW+1:0]        inflight
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned TMYW = WIDTH + 2;
  localparam int unsigned INFW = IDW + 2;
  localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUMW = ((CNTW > INFW) ? CNTW : INFW) + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PW-1:0]  product;
  } rsp_entry_t;

  // Registers
  logic [WIDTH-1:0] r_mul_mx;
  logic [WIDTH-1:0] r_mul_my;
  logic [TMYW-1:0]  r_mul_tmy;
  logic             r_mul_issue;
  logic [IDW-1:0]   r_rr;
  logic [MUL_LAT-1:0] r_tag_vld;
  logic [IDW-1:0]   r_tag_id [MUL_LAT];
  logic [INFW-1:0]  r_inflight;
  rsp_entry_t       r_mem [FIFO_DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [CNTW-1:0]  r_count;

  // Wires
  logic [WIDTH-1:0] w_mx_arr [NREQ];
  logic [WIDTH-1:0] w_my_arr [NREQ];
  logic [2*NREQ-1:0] w_rot;
  logic [IDW-1:0]   w_pos;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_gid;
  logic [IDW-1:0]   w_gid_next;
  logic             w_any;
  logic [SUMW-1:0]  w_total;
  logic             w_can_issue;
  logic             w_issue;
  logic [WIDTH-1:0] w_sel_mx;
  logic [WIDTH-1:0] w_sel_my;
  logic [TMYW-1:0]  w_sel_tmy;
  logic             w_push;
  logic             w_pop;
  rsp_entry_t       w_push_entry;
  rsp_entry_t       w_head;

  // Unpack per-requester operand slices
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_mx_arr[k] = req_mx[k*WIDTH +: WIDTH];
      w_my_arr[k] = req_my[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: rotate the request vector so bit 0 is the rr slot,
  // take the lowest set bit, then map the offset back to a requester id.
  always_comb begin
    w_rot = {req_valid, req_valid} >> r_rr;
    w_pos = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IDW'(i);
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_pos};
    if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
    w_gid = w_sum[IDW-1:0];
  end

  assign w_gid_next = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

  // Credit: registered occupancy only, so a same-cycle pop frees nothing yet
  assign w_any       = |req_valid;
  assign w_total     = SUMW'(r_count) + SUMW'(r_inflight);
  assign w_can_issue = (w_total < SUMW'(FIFO_DEPTH));
  assign w_issue     = w_any & w_can_issue & ~RST;
  assign req_ready   = w_issue ? (NREQ'(1) << w_gid) : '0;

  // Operand select and exact 3*my
  assign w_sel_mx  = w_mx_arr[w_gid];
  assign w_sel_my  = w_my_arr[w_gid];
  assign w_sel_tmy = {2'b00, w_sel_my} + {1'b0, w_sel_my, 1'b0};

  // Operand registers, rr pointer and tag pipeline
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mul_mx    <= '0;
      r_mul_my    <= '0;
      r_mul_tmy   <= '0;
      r_mul_issue <= 1'b0;
      r_rr        <= '0;
      r_tag_vld   <= '0;
      r_inflight  <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_mul_issue <= w_issue;
      if (w_issue) begin
        r_mul_mx  <= w_sel_mx;
        r_mul_my  <= w_sel_my;
        r_mul_tmy <= w_sel_tmy;
        r_rr      <= w_gid_next;
      end
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_gid;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      r_inflight <= r_inflight + INFW'(w_issue) - INFW'(w_push);
    end
  end

  // Result FIFO
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push               = r_tag_vld[MUL_LAT-1];
  assign w_pop                = rsp_valid & rsp_ready;
  assign w_push_entry.id      = r_tag_id[MUL_LAT-1];
  assign w_push_entry.product = mul_product;
  assign w_head               = r_mem[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit check guarantees a push never meets a full FIFO
  always_ff @(posedge CLK) begin
    if (!RST && w_push && !w_pop) assert (r_count < CNTW'(FIFO_DEPTH));
  end

  // Outputs
  assign mul_mx      = r_mul_mx;
  assign mul_my      = r_mul_my;
  assign mul_tmy     = r_mul_tmy;
  assign mul_issue   = r_mul_issue;
  assign rsp_valid   = (r_count != '0);
  assign rsp_id      = w_head.id;
  assign rsp_product = w_head.product;
  assign inflight    = r_inflight;

endmodule

// File: tb/tb_mb32_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mb32_req_arbiter
// Drives mb32_req_arbiter with directed and randomized traffic, stands in for
// the fixed-latency multiplier, and compares every cycle against a queue-based
// reference model of arbitration, credit, pipeline and FIFO behaviour.
// ----------------------------------------------------------------------------
module tb_mb32_req_arbiter;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned IDW        = 2;
  localparam int unsigned MUL_LAT    = 3;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_mx;
  logic [NREQ*WIDTH-1:0] req_my;
  logic [WIDTH-1:0]      mul_mx;
  logic [WIDTH-1:0]      mul_my;
  logic [WIDTH+1:0]      mul_tmy;
  logic                  mul_issue;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic [IDW+1:0]        inflight;

  logic [WIDTH-1:0] tb_mx [NREQ];
  logic [WIDTH-1:0] tb_my [NREQ];

  always #5 CLK = ~CLK;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_mx[k*WIDTH +: WIDTH] = tb_mx[k];
      req_my[k*WIDTH +: WIDTH] = tb_my[k];
    end
  end

  mb32_req_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mx(req_mx), .req_my(req_my),
    .mul_mx(mul_mx), .mul_my(mul_my), .mul_tmy(mul_tmy), .mul_issue(mul_issue),
    .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .inflight(inflight)
  );

  // Multiplier stand-in: operand registers plus MUL_LAT-1 product stages
  logic [2*WIDTH-1:0] mp [MUL_LAT-1];
  always @(posedge CLK) begin
    mp[0] <= (2*WIDTH)'(mul_mx) * (2*WIDTH)'(mul_my);
    for (int i = 1; i < MUL_LAT - 1; i++) mp[i] <= mp[i-1];
  end
  assign mul_product = mp[MUL_LAT-2];

  // Reference model state
  typedef struct {
    int          age;
    int          id;
    logic [63:0] prod;
  } fl_t;

  fl_t         infl[$];
  int          fifo_id[$];
  logic [63:0] fifo_prod[$];
  int          rr_m;
  logic [WIDTH-1:0] m_mx, m_my;
  logic        m_issue;
  logic        m_rst;
  logic [NREQ-1:0] last_ready;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int onehot_id(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v == (NREQ'(1) << k)) return k;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [IDW-1:0] ki;
    if (RST) return '0;
    if (fifo_id.size() + infl.size() >= FIFO_DEPTH) return '0;
    for (int off = 0; off < NREQ; off++) begin
      ki = IDW'((rr_m + off) % NREQ);
      if (req_valid[ki]) return NREQ'(1) << ki;
    end
    return '0;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] rdy);
    fl_t tmp[$];
    int k;
    logic [IDW-1:0] ki;
    m_rst = RST;
    if (RST) begin
      infl.delete(); fifo_id.delete(); fifo_prod.delete();
      rr_m = 0; m_mx = '0; m_my = '0; m_issue = 1'b0;
      return;
    end
    if (fifo_id.size() != 0 && rsp_ready) begin
      void'(fifo_id.pop_front());
      void'(fifo_prod.pop_front());
    end
    foreach (infl[i]) begin
      if (infl[i].age == MUL_LAT - 1) begin
        fifo_id.push_back(infl[i].id);
        fifo_prod.push_back(infl[i].prod);
      end else begin
        tmp.push_back('{age: infl[i].age + 1, id: infl[i].id, prod: infl[i].prod});
      end
    end
    infl = tmp;
    if (rdy != '0) begin
      k  = onehot_id(rdy);
      ki = IDW'(k);
      m_mx = tb_mx[ki];
      m_my = tb_my[ki];
      infl.push_back('{age: 0, id: k, prod: 64'(m_mx) * 64'(m_my)});
      rr_m = (k + 1) % NREQ;
      m_issue = 1'b1;
    end else begin
      m_issue = 1'b0;
    end
  endtask

  // One clock: check grants before the edge, advance model, check outputs after
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    #1;
    exp_ready  = model_ready();
    last_ready = req_ready;
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge CLK);
    model_edge(exp_ready);
    #1;
    check_eq("mul_issue", 64'(mul_issue), 64'(m_issue));
    check_eq("mul_mx", 64'(mul_mx), 64'(m_mx));
    check_eq("mul_my", 64'(mul_my), 64'(m_my));
    check_eq("mul_tmy", 64'(mul_tmy), 64'(m_my) * 64'd3);
    check_eq("inflight", 64'(inflight), 64'(infl.size()));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(fifo_id.size() != 0));
    if (fifo_id.size() != 0) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(fifo_id[0]));
      check_eq("rsp_product", rsp_product, fifo_prod[0]);
    end else if (m_rst) begin
      check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
      check_eq("rst_rsp_product", rsp_product, 64'd0);
    end
  endtask

  // Wait (bounded) for rsp_valid after an issue step; latency counts issue edge
  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 1;
    while (!rsp_valid && lat < 12) begin
      step();
      lat++;
    end
    check_eq(tag, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int grants[$];
    int rsps[$];
    int accepts;

    RST = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin tb_mx[k] = '0; tb_my[k] = '0; end
    rr_m = 0; m_mx = '0; m_my = '0; m_issue = 1'b0; m_rst = 1'b1; last_ready = '0;
    repeat (3) step();
    RST = 1'b0; req_valid = '0;
    repeat (2) step();

    // T1: requester 2, 5*7
    tb_mx[2] = 32'd5; tb_my[2] = 32'd7; req_valid = 4'b0100; rsp_ready = 1'b1;
    step();
    check_eq("t1_grant", 64'(last_ready), 64'h4);
    check_eq("t1_tmy", 64'(mul_tmy), 64'd21);
    req_valid = '0;
    wait_rsp("t1_latency", 4);
    check_eq("t1_id", 64'(rsp_id), 64'd2);
    check_eq("t1_product", rsp_product, 64'd35);
    step();

    // T3: all-ones operands
    tb_mx[1] = 32'hFFFF_FFFF; tb_my[1] = 32'hFFFF_FFFF; req_valid = 4'b0010;
    step();
    check_eq("t3_tmy", 64'(mul_tmy), 64'h2_FFFF_FFFD);
    req_valid = '0;
    wait_rsp("t3_latency", 4);
    check_eq("t3_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
    step();

    // T2: reset rr, all requesters continuously valid
    RST = 1'b1; step(); RST = 1'b0;
    for (int k = 0; k < NREQ; k++) begin tb_mx[k] = 32'(k + 1); tb_my[k] = 32'(100 + k); end
    req_valid = '1; rsp_ready = 1'b1;
    repeat (24) begin
      step();
      if (last_ready != '0) grants.push_back(onehot_id(last_ready));
      if (rsp_valid) rsps.push_back(int'(rsp_id));
    end
    check_eq("t2_grant_count_ge4", 64'(grants.size() >= 4), 64'd1);
    check_eq("t2_rsp_count_ge4", 64'(rsps.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check_eq($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(i));
      if (i < rsps.size()) check_eq($sformatf("t2_rsp%0d", i), 64'(rsps[i]), 64'(i));
    end

    // T4: backpressure with requester 0 streaming
    req_valid = '0; rsp_ready = 1'b1;
    repeat (8) step();
    rsp_ready = 1'b0; req_valid = 4'b0001;
    accepts = 0;
    repeat (12) begin
      tb_mx[0] = $urandom; tb_my[0] = $urandom;
      step();
      if (last_ready[0]) accepts++;
    end
    check_eq("t4_accepts", 64'(accepts), 64'(FIFO_DEPTH));
    rsp_ready = 1'b1;
    step();
    check_eq("t4_no_credit_on_pop", 64'(last_ready), 64'h0);
    step();
    check_eq("t4_credit_after_pop", 64'(last_ready), 64'h1);

    // T6: reset with ops both in flight and in the FIFO
    req_valid = '0; rsp_ready = 1'b1;
    repeat (10) step();
    rsp_ready = 1'b0; req_valid = 4'b1000;
    repeat (4) begin tb_mx[3] = $urandom; tb_my[3] = $urandom; step(); end
    req_valid = '0;
    step();
    check_eq("t6_pre_inflight", 64'(inflight), 64'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_eq("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("t6_inflight", 64'(inflight), 64'd0);
    rsp_ready = 1'b1; req_valid = '1; tb_mx[0] = 32'd3; tb_my[0] = 32'd9;
    step();
    check_eq("t6_rr_zero", 64'(last_ready), 64'h1);
    req_valid = '0;
    wait_rsp("t6_latency", 4);
    check_eq("t6_id", 64'(rsp_id), 64'd0);
    check_eq("t6_product", rsp_product, 64'd27);

    // Randomized traffic with occasional reset and bursty backpressure
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 149) == 0);
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        case ($urandom_range(0, 7))
          0:       tb_mx[k] = '0;
          1:       tb_mx[k] = '1;
          default: tb_mx[k] = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0:       tb_my[k] = '0;
          1:       tb_my[k] = '1;
          default: tb_my[k] = $urandom;
        endcase
      end
      if (c < 1500) rsp_ready = ($urandom_range(0, 3) != 0);
      else          rsp_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
